// File: rtl/mult_accumulator.sv
// Signed group accumulator fed by the Booth multiplier: sums products up to in_last, then holds the total.
// Build option: define MAC_SATURATE_EN to clamp the accumulator on signed overflow instead of wrapping.
module mult_accumulator #(
  parameter int NR_BITS  = 4,
  parameter int ACC_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2*NR_BITS-1:0] in_product_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACC_BITS-1:0]  out_acc_o,
  output logic [7:0]           out_count_o,
  output logic                 out_overflow_o,
  output logic                 dbg_state_o
);

  localparam int PW = 2 * NR_BITS;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Valid never waits on ready; ready and valid here are decoded from registered state only.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [ACC_BITS-1:0] acc_q;
  logic [ACC_BITS-1:0] acc_d;
  logic [7:0]          count_q;
  logic [7:0]          count_d;
  logic                ovf_q;
  logic                ovf_d;

  logic signed [PW-1:0] prod_s;
  logic [ACC_BITS-1:0]  prod_ext;
  logic [ACC_BITS-1:0]  sum;
  logic                 add_ovf;

`ifdef MAC_SATURATE_EN
  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
`endif

  assign prod_s   = $signed(in_product_i);
  assign prod_ext = ACC_BITS'(prod_s);

  always_comb begin
    sum     = acc_q + prod_ext;
    // Overflow: operands share a sign and the result sign differs from it.
    add_ovf = (acc_q[ACC_BITS-1] == prod_ext[ACC_BITS-1]) &&
              (sum[ACC_BITS-1] != acc_q[ACC_BITS-1]);
    acc_d   = sum;
`ifdef MAC_SATURATE_EN
    if (add_ovf) begin
      acc_d = acc_q[ACC_BITS-1] ? ACC_MIN : ACC_MAX;
    end
`endif
    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    ovf_d   = ovf_q | add_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid_i) begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (in_last_i) begin
              state_q     <= ST_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Release clears the group; ready returns one cycle later (no bypass).
          if (out_ready_i) begin
            state_q     <= ST_ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_acc_o      = acc_q;
  assign out_count_o    = count_q;
  assign out_overflow_o = ovf_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: a 16-bit and an 8-bit accumulator instance behind one shared driver.
module tb_mult_accumulator;

  localparam int PW = 8;

`ifdef MAC_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [PW-1:0] in_product;
  logic          in_last;
  logic          out_ready;
  logic          sel;
  logic          rand_ready;
  logic          ready_force;

  logic        in_ready_a, out_valid_a, ovf_a, dbg_a;
  logic [15:0] acc_a;
  logic [7:0]  cnt_a;
  logic        in_ready_b, out_valid_b, ovf_b, dbg_b;
  logic [7:0]  acc_b;
  logic [7:0]  cnt_b;

  logic        in_ready, out_valid, out_overflow, dbg_state;
  logic [15:0] out_acc;
  logic [7:0]  out_count;

  mult_accumulator #(.NR_BITS(4), .ACC_BITS(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid & ~sel), .in_ready_o(in_ready_a),
    .in_product_i(in_product), .in_last_i(in_last),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .out_acc_o(acc_a), .out_count_o(cnt_a), .out_overflow_o(ovf_a),
    .dbg_state_o(dbg_a)
  );

  mult_accumulator #(.NR_BITS(4), .ACC_BITS(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid & sel), .in_ready_o(in_ready_b),
    .in_product_i(in_product), .in_last_i(in_last),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .out_acc_o(acc_b), .out_count_o(cnt_b), .out_overflow_o(ovf_b),
    .dbg_state_o(dbg_b)
  );

  assign in_ready     = sel ? in_ready_b  : in_ready_a;
  assign out_valid    = sel ? out_valid_b : out_valid_a;
  assign out_acc      = sel ? {{8{acc_b[7]}}, acc_b} : acc_a;
  assign out_count    = sel ? cnt_b : cnt_a;
  assign out_overflow = sel ? ovf_b : ovf_a;
  assign dbg_state    = sel ? dbg_b : dbg_a;

  // ---------------- scoreboard ----------------
  int n_pass;
  int n_total;
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [24:0] res(input int acc, input int cnt, input logic ovf);
    logic [24:0] r;
    r = {acc[15:0], cnt[7:0], ovf};
    return r;
  endfunction

  // Downstream ready: random or forced, updated just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Result monitor: the release happens on the next rising edge.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got acc=0x%0h cnt=%0d, want none", out_acc, out_count);
        end else begin
          e = exp_q.pop_front();
          check("result", {7'd0, out_acc, out_count, out_overflow}, {7'd0, e});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic send_term(input logic [PW-1:0] p, input logic last);
    logic ok;
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: product 0x%0h not accepted, want accepted", p);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d results pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic            sel;
    logic [2:0]      n;
    logic [3:0][7:0] p;
    logic [15:0]     acc;
    logic [7:0]      cnt;
    logic            ovf;
  } vec_t;

  function automatic vec_t mk(input logic s, input int n, input int p0, input int p1,
                              input int p2, input int p3, input int acc, input int cnt,
                              input logic ovf);
    vec_t v;
    v.sel  = s;
    v.n    = n[2:0];
    v.p[0] = p0[7:0];
    v.p[1] = p1[7:0];
    v.p[2] = p2[7:0];
    v.p[3] = p3[7:0];
    v.acc  = acc[15:0];
    v.cnt  = cnt[7:0];
    v.ovf  = ovf;
    return v;
  endfunction

  vec_t vecs[10];

  // ---------------- main sequence ----------------
  initial begin
    n_pass = 0;
    n_total = 0;
    in_valid = 1'b0;
    in_product = '0;
    in_last = 1'b0;
    sel = 1'b0;
    rand_ready = 1'b0;
    ready_force = 1'b0;
    rst_n = 1'b0;

    vecs[0] = mk(0, 3, 12, -6, 64, 0, 70, 3, 1'b0);
    vecs[1] = mk(0, 1, 3, 0, 0, 0, 3, 1, 1'b0);
    vecs[2] = mk(0, 4, -100, -27, 5, 2, -120, 4, 1'b0);
    vecs[3] = mk(0, 3, -128, -128, 127, 0, -129, 3, 1'b0);
    vecs[4] = mk(0, 2, 127, 127, 0, 0, 254, 2, 1'b0);
    vecs[5] = mk(1, 2, 64, 64, 0, 0, SAT ? 127 : -128, 2, 1'b1);
    vecs[6] = mk(1, 3, 64, 64, -8, 0, SAT ? 119 : 120, 3, 1'b1);
    vecs[7] = mk(1, 3, -64, -64, -8, 0, SAT ? -128 : 120, 3, 1'b1);
    vecs[8] = mk(1, 2, -64, -64, 0, 0, -128, 2, 1'b0);
    vecs[9] = mk(1, 1, -128, 0, 0, 0, -128, 1, 1'b0);

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_acc_cnt_ovf", {7'd0, out_acc, out_count, out_overflow}, 32'd0);
    check("reset_state", {31'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Partial group discarded by a mid-group reset.
    send_term(8'd5, 1'b0);
    send_term(8'd7, 1'b0);
    check("partial_running", {7'd0, out_acc, out_count, out_overflow}, {7'd0, res(12, 2, 1'b0)});
    rst_n = 1'b0;
    #1;
    check("midreset_ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
    check("midreset_acc_cnt", {7'd0, out_acc, out_count, out_overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
    check("post_reset_acc_cnt", {7'd0, out_acc, out_count, out_overflow}, 32'd0);
    ready_force = 1'b1;
    exp_q.push_back(res(3, 1, 1'b0));
    send_term(8'd3, 1'b1);
    drain();

    // Basic group, latency, then backpressure with a pending product.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(res(70, 3, 1'b0));
    send_term(8'd12, 1'b0);
    send_term(8'hFA, 1'b0);
    send_term(8'd64, 1'b1);
    check("latency_valid_ready", {30'd0, in_ready, out_valid}, 32'b01);
    check("latency_state", {31'd0, dbg_state}, 32'd1);
    check("latency_result", {7'd0, out_acc, out_count, out_overflow}, {7'd0, res(70, 3, 1'b0)});
    in_valid = 1'b1;
    in_product = 8'd9;
    in_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_ready_valid", {30'd0, in_ready, out_valid}, 32'b01);
      check("hold_stable", {7'd0, out_acc, out_count, out_overflow}, {7'd0, res(70, 3, 1'b0)});
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    check("no_bypass_ready_valid", {30'd0, in_ready, out_valid}, 32'b10);
    check("no_bypass_cleared", {7'd0, out_acc, out_count, out_overflow}, 32'd0);
    @(posedge clk);
    #1;
    check("pending_accepted", {7'd0, out_acc, out_count, out_overflow}, {7'd0, res(9, 1, 1'b0)});
    in_valid = 1'b0;
    exp_q.push_back(res(10, 2, 1'b0));
    send_term(8'd1, 1'b1);
    drain();

    // Table-driven groups with random gaps and random downstream ready.
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].sel != sel) begin
        drain();
        sel = vecs[i].sel;
      end
      exp_q.push_back({vecs[i].acc, vecs[i].cnt, vecs[i].ovf});
      for (int t = 0; t < int'(vecs[i].n); t++) begin
        send_term(vecs[i].p[t], t == int'(vecs[i].n) - 1);
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rand_ready = 1'b0;
    ready_force = 1'b1;
    sel = 1'b0;
    @(posedge clk);
    #1;

    // Count saturation, then a back-to-back single-term group.
    exp_q.push_back(res(300, 255, 1'b0));
    exp_q.push_back(res(-1, 1, 1'b0));
    for (int t = 0; t < 300; t++) send_term(8'd1, t == 299);
    check("sat_count_hold", {30'd0, in_ready, out_valid}, 32'b01);
    send_term(8'hFF, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Sequential signed accumulator that sits directly downstream of the combinational Booth multiplier. It consumes a stream of 2·NR_BITS-bit two's-complement products over a valid/ready handshake and sums each group, delimited by a last flag, into a wide accumulator. The group total is held on an output handshake until it is taken. A term count and a sticky overflow flag accompany the total.

## Interface
- NR_BITS, 4, operand width of the upstream multiplier; products are 2·NR_BITS bits.
- ACC_BITS, 16, accumulator width; must be ≥ 2·NR_BITS.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  block can accept a product.
- in_product  input  2·NR_BITS  signed product.
- in_last  input  1  product is the final term of the group; sampled with in_product.
- out_valid  output  1  group result available.
- out_ready  input  1  downstream takes the result.
- out_acc  output  ACC_BITS  signed group sum.
- out_count  output  8  number of terms in the group.
- out_overflow  output  1  a signed overflow occurred at least once in the group.

## Operation
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- An input transfer occurs when in_valid & in_ready at a rising edge. A transfer in ACCUM:
  - acc ← acc + sign-extend(in_product) to ACC_BITS.
  - count ← count+1, saturating at 255.
  - overflow ← overflow | (signed overflow of this add). Overflow means the operand signs are equal and the result sign differs.
  - If in_last=1, the next state is HOLD; otherwise the state stays ACCUM.
- In HOLD, out_acc, out_count and out_overflow are stable and equal the completed group values.
- HOLD → ACCUM on out_valid & out_ready at a rising edge. On that edge acc, count and overflow clear to 0.
- No bypass: a product cannot be accepted in the same cycle a result is released. in_ready rises the cycle after release.
- in_product and in_last are ignored when no transfer occurs.
- A single-term group (in_last on the first product) is legal: out_count=1.
- In ACCUM, out_acc, out_count and out_overflow show the running partial values. They are meaningful only while out_valid=1.

## Timing
- Reset (rst_n=0, any time, including mid-group or in HOLD): state=ACCUM, acc=0, count=0, overflow=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_acc=0, out_count=0, out_overflow=0.
  - Any partial group is discarded.
- Throughput: one product per cycle in ACCUM.
- Latency: a last product accepted at edge k gives out_valid=1 from just after edge k, and out_acc includes that product.
- in_ready and out_valid are decoded from state only; no combinational path from in_valid or out_ready.
- Downstream may hold out_ready high indefinitely. Back-to-back groups then cost one dead input cycle per group.

## Configuration
- MAC_SATURATE_EN defined: on a signed overflow, acc clamps instead of wrapping.
  - Positive overflow clamps to 2^(ACC_BITS-1)-1; negative overflow clamps to -2^(ACC_BITS-1).
  - Later terms add to the clamped value.
  - out_overflow is still set.
- MAC_SATURATE_EN undefined: acc wraps modulo 2^ACC_BITS (two's complement). out_overflow is still set.

## Test plan
- Reset check: assert rst_n=0 mid-group after products 5, 7 (no last); release → out_valid=0, in_ready=1, out_acc=0, out_count=0. Next group 3 (last) → out_acc=3, out_count=1.
- Basic group (NR_BITS=4, ACC_BITS=16): products 12, -6, 64 (last) on consecutive cycles → out_valid=1 the cycle after the third transfer; out_acc=70, out_count=3, out_overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 → in_ready=0 throughout; outputs stable at 70/3/0; product not consumed. Assert out_ready → release, then in_ready=1 next cycle and the pending product is accepted.
- Overflow wrap (ACC_BITS=8, macro undefined): 64, 64 (last) → out_acc=0x80 (-128), out_overflow=1.
- Overflow saturate (ACC_BITS=8, MAC_SATURATE_EN defined): 64, 64, -8 (last) → out_acc=119 (127-8), out_overflow=1. Repeat with -64, -64, -8 (last) → out_acc=-128, out_overflow=1.
- Count saturation and back-to-back: 300 products of value 1, the last flagged → out_count=255, out_acc=300. A following single-term group of -1 → out_acc=-1, out_count=1, out_overflow=0.
